network_link_pipe: RTL
======================

# network_link_pipe

Parametrised, pipelined inter-router link for the mesh/torus network top levels. It carries one router-to-router channel downstream and the matching credit flow-control bundle upstream, with independently configurable register depth in each direction, so that long links such as torus wrap-around links can be retimed. An optional per-VC credit checker flags protocol violations on the link.

## Interface
- `num_vcs`, 4: VCs per link; `vc_idx_width = clogb(num_vcs)`.
- `buffer_size`, 8: input buffer entries per downstream port. Credits per VC are `buffer_size/num_vcs`, which must be an integer and ≥1.
- `link_ctrl_width`, 0: leading link-management bits in the channel (0 or 1).
- `flit_ctrl_width`, `1+vc_idx_width+2`: flit control bits.
- `flit_data_width`, 64: payload bits.
- `channel_width`: `link_ctrl_width + flit_ctrl_width + flit_data_width`.
- `flow_ctrl_width`: `1 + vc_idx_width`.
- `fwd_stages`, 1: channel register stages, 0–8. A value of 0 is a combinational pass-through.
- `rev_stages`, 1: flow-control register stages, 0–8. A value of 0 is a combinational pass-through.

Ports:
- `clk`, input, 1: the single clock.
- `reset`, input, 1: asynchronous, active-low reset. Reset is asserted when `reset`=0.
- `channel_in`, input, `channel_width`: channel from the upstream router output port.
- `channel_out`, output, `channel_width`: channel to the downstream router input port.
- `flow_ctrl_in`, input, `flow_ctrl_width`: credits from the downstream router.
- `flow_ctrl_out`, output, `flow_ctrl_width`: credits to the upstream router.
- `link_idle`, output, 1: no flit or credit is in flight (see Operation).
- `error`, output, 1: sticky credit-protocol violation.

## Operation
- Field positions, MSB-first `[0:w-1]`:
  - flit valid is channel bit `link_ctrl_width`;
  - the flit VC occupies the next `vc_idx_width` bits;
  - credit valid is flow_ctrl bit 0;
  - the credit VC occupies bits `1..vc_idx_width`.
- Forward path: a shift register of `fwd_stages` entries, each the full `channel_width`. Every cycle each stage loads the previous one. The link has no stall; the flow control is credit-based, so the link is always ready.
- Reverse path: the same structure, `rev_stages` deep, of width `flow_ctrl_width`.
- Contents are copied verbatim. All bits, including invalid-flit payloads, propagate unchanged.
- `link_idle` is 1 when:
  - the valid bits of all forward and reverse stages are 0, and
  - with the checker compiled in, every VC counter is 0.
- It is combinational from the registers only.

## Timing
- Forward latency is exactly `fwd_stages` cycles; reverse latency is exactly `rev_stages` cycles.
- Throughput is one flit and one credit per cycle, with no bubbles.
- Reset clears every pipeline stage to all-zero. During and after reset:
  - `channel_out` = 0, `flow_ctrl_out` = 0 (for stage counts >0);
  - `error` = 0;
  - `link_idle` = 1 (for 0-stage paths, it is driven from the inputs).
- Reset asserted mid-stream discards all in-flight flits and credits immediately (asynchronously). The first post-reset input emerges `fwd_stages`/`rev_stages` cycles after the first clock edge with `reset`=1.

## Configuration
- `LINK_CREDIT_CHECK_EN` defined:
  - The block keeps one counter per VC, of width `clogb(buffer_size/num_vcs + 1)`, reset to 0.
  - A counter increments on a valid flit at `channel_in` for its VC.
  - It decrements on a valid credit at `flow_ctrl_in` for its VC.
  - If both happen on the same VC in the same cycle, the counter is unchanged.
  - Overflow: an increment at count `buffer_size/num_vcs` without a matching decrement.
  - Underflow: a decrement at count 0 without a matching increment.
  - On overflow or underflow, `error` is set on the next edge. It stays set until reset, and the counter saturates instead of wrapping.
- `LINK_CREDIT_CHECK_EN` undefined:
  - No counters are built, and `error` is tied to 0.
  - `link_idle` depends on the pipeline valid bits only.

## Test plan
- Reset: hold `reset`=0 with random inputs and `fwd_stages`=`rev_stages`=2 → `channel_out`=0, `flow_ctrl_out`=0, `error`=0, `link_idle`=1. Then release `reset`.
- Forward latency: `fwd_stages`=3, drive a valid flit with VC 2 and data 0xDEADBEEF at cycle 0, then 8 back-to-back flits → the first appears bit-exact at cycle 3, followed by 8 contiguous flits; `link_idle`=0 until drained.
- Credit path and pass-through: with `rev_stages`=0, a credit for VC 1 appears on `flow_ctrl_out` in the same cycle. With `rev_stages`=2, it appears 2 cycles later.
- Overflow (`LINK_CREDIT_CHECK_EN`, `buffer_size`=8, `num_vcs`=2): send 5 flits on VC 0 with no credits → `error` rises on the edge after the 5th flit and stays 1.
- Underflow and simultaneous events (`LINK_CREDIT_CHECK_EN`):
  - a credit on VC 1 at count 0 → `error`=1;
  - in a separate run, at VC 0 count 4, a flit and a credit on VC 0 in the same cycle → `error` stays 0 and the count stays 4.
- Mid-stream reset: assert `reset`=0 while 3 flits are in flight → outputs go to 0 at once, `error` clears, and `link_idle`=1 after the counters clear.

Source files
------------

// File: rtl/network_link_pipe.sv
// network_link_pipe
//
// Pipelined router-to-router link. The channel travels downstream through
// fwd_stages registers and the credit bundle travels upstream through
// rev_stages registers. A stage count of 0 turns that direction into a wire.
// There is no stall: credit flow control guarantees the far end always
// accepts, so every stage reloads every cycle.
//
// Vectors use MSB-first numbering [0:w-1]:
//   channel bit link_ctrl_width           flit valid
//   next vc_idx_width channel bits        flit VC
//   flow_ctrl bit 0                       credit valid
//   flow_ctrl bits 1..vc_idx_width        credit VC
//
// Optional feature macro: LINK_CREDIT_CHECK_EN
//   When defined, one credit counter per VC watches the link inputs and raises
//   a sticky error on overflow or underflow. When undefined, error is 0.
//
// Ports:
//   clk            single clock
//   reset          asynchronous, active-low reset
//   channel_in     channel from the upstream router output port
//   channel_out    channel to the downstream router input port
//   flow_ctrl_in   credits from the downstream router
//   flow_ctrl_out  credits to the upstream router
//   link_idle      no flit or credit in flight (and all counters 0 if checked)
//   error          sticky credit-protocol violation

module network_link_pipe #(
    parameter  int num_vcs         = 4,
    parameter  int buffer_size     = 8,
    parameter  int link_ctrl_width = 0,
    localparam int vc_idx_width    = $clog2(num_vcs),
    parameter  int flit_ctrl_width = 1 + vc_idx_width + 2,
    parameter  int flit_data_width = 64,
    parameter  int fwd_stages      = 1,
    parameter  int rev_stages      = 1,
    localparam int channel_width   = link_ctrl_width + flit_ctrl_width + flit_data_width,
    localparam int flow_ctrl_width = 1 + vc_idx_width
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [0:channel_width-1]   channel_in,
    output logic [0:channel_width-1]   channel_out,
    input  logic [0:flow_ctrl_width-1] flow_ctrl_in,
    output logic [0:flow_ctrl_width-1] flow_ctrl_out,
    output logic                       link_idle,
    output logic                       error
);

    // Credits per VC must be a whole number of at least one.
    if ((buffer_size % num_vcs) != 0 || buffer_size < num_vcs) begin : g_bad_credit_cfg
        $error("network_link_pipe: buffer_size must be a positive multiple of num_vcs");
    end

    logic w_fwd_busy;
    logic w_rev_busy;
    logic w_cnt_busy;

    // Forward (channel) path
    if (fwd_stages == 0) begin : g_fwd_pass
        assign channel_out = channel_in;
        assign w_fwd_busy  = channel_in[link_ctrl_width];
    end else begin : g_fwd_pipe
        logic [0:channel_width-1] r_fwd [fwd_stages];

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                for (int i = 0; i < fwd_stages; i++) r_fwd[i] <= '0;
            end else begin
                r_fwd[0] <= channel_in;
                for (int i = 1; i < fwd_stages; i++) r_fwd[i] <= r_fwd[i-1];
            end
        end

        assign channel_out = r_fwd[fwd_stages-1];

        always_comb begin
            w_fwd_busy = 1'b0;
            for (int i = 0; i < fwd_stages; i++) w_fwd_busy = w_fwd_busy | r_fwd[i][link_ctrl_width];
        end
    end

    // Reverse (credit) path
    if (rev_stages == 0) begin : g_rev_pass
        assign flow_ctrl_out = flow_ctrl_in;
        assign w_rev_busy    = flow_ctrl_in[0];
    end else begin : g_rev_pipe
        logic [0:flow_ctrl_width-1] r_rev [rev_stages];

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                for (int i = 0; i < rev_stages; i++) r_rev[i] <= '0;
            end else begin
                r_rev[0] <= flow_ctrl_in;
                for (int i = 1; i < rev_stages; i++) r_rev[i] <= r_rev[i-1];
            end
        end

        assign flow_ctrl_out = r_rev[rev_stages-1];

        always_comb begin
            w_rev_busy = 1'b0;
            for (int i = 0; i < rev_stages; i++) w_rev_busy = w_rev_busy | r_rev[i][0];
        end
    end

`ifdef LINK_CREDIT_CHECK_EN
    localparam int credits_per_vc = buffer_size / num_vcs;
    localparam int cnt_width      = $clog2(credits_per_vc + 1);
    localparam logic [cnt_width-1:0] CNT_MAX = cnt_width'(credits_per_vc);

    logic [cnt_width-1:0]    r_cnt [num_vcs];
    logic                    r_error;
    logic                    w_flit_v;
    logic                    w_cred_v;
    logic [vc_idx_width-1:0] w_flit_vc;
    logic [vc_idx_width-1:0] w_cred_vc;
    logic [num_vcs-1:0]      w_inc;
    logic [num_vcs-1:0]      w_dec;

    // Counters watch the link inputs, so they track credits owed regardless of
    // how deep either pipeline is.
    assign w_flit_v  = channel_in[link_ctrl_width];
    assign w_flit_vc = channel_in[link_ctrl_width+1 +: vc_idx_width];
    assign w_cred_v  = flow_ctrl_in[0];
    assign w_cred_vc = flow_ctrl_in[1 +: vc_idx_width];

    always_comb begin
        w_inc = '0;
        w_dec = '0;
        for (int v = 0; v < num_vcs; v++) begin
            w_inc[v] = w_flit_v && (w_flit_vc == vc_idx_width'(v));
            w_dec[v] = w_cred_v && (w_cred_vc == vc_idx_width'(v));
        end
    end

    // A flit and a credit on the same VC cancel. On a violation the counter
    // holds (saturates) and the error latches until reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int v = 0; v < num_vcs; v++) r_cnt[v] <= '0;
            r_error <= 1'b0;
        end else begin
            for (int v = 0; v < num_vcs; v++) begin
                if (w_inc[v] && !w_dec[v]) begin
                    if (r_cnt[v] == CNT_MAX) r_error <= 1'b1;
                    else                     r_cnt[v] <= r_cnt[v] + 1'b1;
                end else if (w_dec[v] && !w_inc[v]) begin
                    if (r_cnt[v] == '0) r_error <= 1'b1;
                    else                r_cnt[v] <= r_cnt[v] - 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_cnt_busy = 1'b0;
        for (int v = 0; v < num_vcs; v++) begin
            if (r_cnt[v] != '0) w_cnt_busy = 1'b1;
        end
    end

    assign error = r_error;
`else
    assign w_cnt_busy = 1'b0;
    assign error      = 1'b0;
`endif

    assign link_idle = !(w_fwd_busy || w_rev_busy || w_cnt_busy);

endmodule
